column_buffer: RTL and testbench
================================

// Module: column_buffer
// PURPOSE
//  Double-buffered per-column store of wall distance and texture-U words feeding the GPU.
//  CPU side writes the back bank. GPU side reads the front bank by column index.
//  Bank swap handshake: buffer_select toggles, then waits until GPU reading_buffer (latched in vsync) matches it.
// PARAMETERS
//  COLUMNS      320  valid column entries per bank
//  INDEX_WIDTH  9    column index width
//  DATA_WIDTH   16   width of distance and texture words
// PORTS
//  clk            in   1   system clock
//  clr            in   1   synchronous reset, active-high
//  wr_en          in   1   CPU write strobe, accepted only when wr_ready=1
//  wr_sel         in   1   0 = distance word, 1 = texture word
//  wr_index       in   9   column to write, back bank
//  wr_data        in   16  write data
//  wr_ready       out  1   high when back bank is writable (state IDLE)
//  wr_dropped     out  1   sticky: a write was discarded; cleared by clr or swap_req
//  swap_req       in   1   1-cycle pulse: back bank complete, make it front
//  swap_done      out  1   1-cycle pulse when GPU has adopted new front bank
//  buffer_select  out  1   current front bank, to GPU buffer_select
//  read_buffer    in   1   GPU reading_buffer (bank GPU is actually reading)
//  read_index     in   9   GPU reading_index
//  distance       out  16  registered distance, to GPU distance
//  texture        out  16  registered texture word, to GPU texture
// BEHAVIOUR
//  Storage: 2 banks x COLUMNS x {distance, texture}. Contents not reset.
//  Read path: 1-cycle latency; distance/texture at edge N+1 reflect read_buffer/read_index at edge N.
//  Read with read_index >= COLUMNS (incl. wrapped/underflowed GPU index): distance=16'hFFFF, texture=16'h0000.
//  Read and write to same bank+index in same cycle: read returns old data.
//  Write: wr_en && wr_ready && wr_index<COLUMNS -> mem[~buffer_select][wr_index][wr_sel] = wr_data.
//  Write with wr_ready=0 or wr_index>=COLUMNS: discarded, wr_dropped set next cycle.
//  FSM states:
//   - IDLE: wr_ready=1. swap_req -> buffer_select toggles next edge, go WAIT_LATCH.
//   - WAIT_LATCH: wr_ready=0. When read_buffer==buffer_select -> swap_done=1 for one cycle, go IDLE.
//  Check uses the registered buffer_select; earliest exit is the cycle after the toggle.
//  swap_req in WAIT_LATCH: ignored; no second toggle; wr_dropped not cleared.
//  wr_en and swap_req same cycle in IDLE: write lands in old back bank, then the toggle occurs. Data is visible after the swap.
//  No timeout: WAIT_LATCH holds indefinitely until GPU latches (one frame max in normal operation).
//  Reset values:
//   - state = WAIT_LATCH, buffer_select=0, wr_ready=0.
//   - swap_done=0, wr_dropped=0, distance=16'hFFFF, texture=0.
//   - Reset into WAIT_LATCH so the CPU cannot write a bank the GPU may still read. A mid-swap clr behaves identically.
//  swap_done and wr_ready are registered outputs of the FSM.
// TESTING
//  1. clr with read_buffer=1 -> wr_ready=0, buffer_select=0. Drive read_buffer=0 -> swap_done pulse, wr_ready=1 next cycle.
//  2. IDLE, bsel=0: write idx 5 dist=16'h0123, tex=16'h002A. swap_req, read_buffer->1. read_index=5 -> distance=16'h0123, texture=16'h002A one cycle later.
//  3. read_index=319 -> stored value; read_index=320 and 9'h1FF -> distance=16'hFFFF, texture=0.
//  4. swap_req then wr_en during WAIT_LATCH -> write discarded, wr_dropped=1, back-bank entry unchanged. Second swap_req -> buffer_select toggles once only.
//  5. Same-cycle wr_en (idx 7, 16'hBEEF) + swap_req in IDLE -> after GPU latch, read idx 7 = 16'hBEEF.
//  6. clr asserted in WAIT_LATCH with buffer_select=1 -> buffer_select=0, wr_ready=0 until read_buffer=0.

Source files
------------

// File: rtl/column_buffer_if.sv
// column_buffer_if: CPU write port, bank-swap handshake and GPU read port of the column buffer.
interface column_buffer_if #(
    parameter int INDEX_WIDTH = 9,
    parameter int DATA_WIDTH  = 16
);
    logic                   wr_en;
    logic                   wr_sel;
    logic [INDEX_WIDTH-1:0] wr_index;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   wr_ready;
    logic                   wr_dropped;
    logic                   swap_req;
    logic                   swap_done;
    logic                   buffer_select;
    logic                   read_buffer;
    logic [INDEX_WIDTH-1:0] read_index;
    logic [DATA_WIDTH-1:0]  distance;
    logic [DATA_WIDTH-1:0]  texture;

    modport master (
        output wr_en, wr_sel, wr_index, wr_data, swap_req, read_buffer, read_index,
        input  wr_ready, wr_dropped, swap_done, buffer_select, distance, texture
    );

    modport slave (
        input  wr_en, wr_sel, wr_index, wr_data, swap_req, read_buffer, read_index,
        output wr_ready, wr_dropped, swap_done, buffer_select, distance, texture
    );
endinterface

// File: rtl/column_buffer.sv
// column_buffer: double-buffered per-column distance/texture store; CPU fills the back bank, GPU reads the front.
module column_buffer #(
    parameter int COLUMNS     = 320,
    parameter int INDEX_WIDTH = 9,
    parameter int DATA_WIDTH  = 16
) (
    input logic            clk,
    input logic            clr,
    column_buffer_if.slave bus
);
    typedef enum logic {IDLE, WAIT_LATCH} state_t;

    localparam logic [INDEX_WIDTH:0] COLS = (INDEX_WIDTH + 1)'(COLUMNS);

    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] dist_mem [2][COLUMNS];
    logic [DATA_WIDTH-1:0] tex_mem  [2][COLUMNS];
    logic wr_in_range, rd_in_range, wr_accept, swap_accept;
    logic sel_nx, ready_nx, done_nx, dropped_nx;

    always_comb begin
        wr_in_range = {1'b0, bus.wr_index} < COLS;
        rd_in_range = {1'b0, bus.read_index} < COLS;
        wr_accept   = bus.wr_en && bus.wr_ready && wr_in_range;
        swap_accept = (state == IDLE) && bus.swap_req;
        state_nx    = (state == IDLE) ? (bus.swap_req ? WAIT_LATCH : IDLE)
                                      : ((bus.read_buffer == bus.buffer_select) ? IDLE : WAIT_LATCH);
        done_nx     = (state == WAIT_LATCH) && (bus.read_buffer == bus.buffer_select);
        ready_nx    = state_nx == IDLE;
        sel_nx      = bus.buffer_select ^ swap_accept;
        // A drop in the swap cycle itself survives the clear, so it is never lost.
        dropped_nx  = (bus.wr_en && !wr_accept) || (bus.wr_dropped && !swap_accept);
    end

    // Reset lands in WAIT_LATCH so the CPU cannot touch a bank the GPU may still be reading.
    always_ff @(posedge clk) begin
        if (clr) begin
            state             <= WAIT_LATCH;
            bus.buffer_select <= 1'b0;
            bus.wr_ready      <= 1'b0;
            bus.swap_done     <= 1'b0;
            bus.wr_dropped    <= 1'b0;
        end else begin
            state             <= state_nx;
            bus.buffer_select <= sel_nx;
            bus.wr_ready      <= ready_nx;
            bus.swap_done     <= done_nx;
            bus.wr_dropped    <= dropped_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && bus.wr_sel)
            tex_mem[~bus.buffer_select][bus.wr_index] <= bus.wr_data;
        if (wr_accept && !bus.wr_sel)
            dist_mem[~bus.buffer_select][bus.wr_index] <= bus.wr_data;
    end

    // Out-of-range columns read as "infinitely far, no texture".
    always_ff @(posedge clk) begin
        if (clr) begin
            bus.distance <= '1;
            bus.texture  <= '0;
        end else begin
            bus.distance <= rd_in_range ? dist_mem[bus.read_buffer][bus.read_index] : '1;
            bus.texture  <= rd_in_range ? tex_mem[bus.read_buffer][bus.read_index] : '0;
        end
    end
endmodule

// File: tb/tb_column_buffer.sv
// tb_column_buffer: directed stimulus with a read-data scoreboard and inline handshake checks.
module tb_column_buffer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] t;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;

    column_buffer_if #(.INDEX_WIDTH(9), .DATA_WIDTH(16)) bus ();

    column_buffer #(.COLUMNS(320), .INDEX_WIDTH(9), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic bank, input logic [8:0] idx, input logic [15:0] d, input logic [15:0] t, input string name);
        bus.read_buffer = bank;
        bus.read_index  = idx;
        sb.push_back('{d: d, t: t, name: name});
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [8:0] idx, input logic [15:0] data, input logic swap);
        bus.wr_en    = 1'b1;
        bus.wr_sel   = sel;
        bus.wr_index = idx;
        bus.wr_data  = data;
        bus.swap_req = swap;
        tick();
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
    endtask

    task automatic swap();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got read data with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_dist"}, 32'(bus.distance), 32'(e.d));
                chk({e.name, "_tex"}, 32'(bus.texture), 32'(e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_index = 0; bus.wr_data = 0;
        bus.swap_req = 0; bus.read_buffer = 1; bus.read_index = 0;
        tick(2);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_bsel", 32'(bus.buffer_select), 0);
        chk("rst_swap_done", 32'(bus.swap_done), 0);
        chk("rst_dropped", 32'(bus.wr_dropped), 0);
        chk("rst_dist", 32'(bus.distance), 32'hFFFF);
        chk("rst_tex", 32'(bus.texture), 0);
        clr = 1'b0;
        tick();
        chk("t1_hold_ready", 32'(bus.wr_ready), 0);
        chk("t1_hold_done", 32'(bus.swap_done), 0);
        bus.read_buffer = 0;
        tick();
        chk("t1_done", 32'(bus.swap_done), 1);
        chk("t1_ready", 32'(bus.wr_ready), 1);
        tick();
        chk("t1_done_pulse", 32'(bus.swap_done), 0);
        chk("t1_ready_hold", 32'(bus.wr_ready), 1);

        wr(0, 5, 16'h0123, 0);
        wr(1, 5, 16'h002A, 0);
        wr(0, 319, 16'h1319, 0);
        wr(1, 319, 16'h2319, 0);
        chk("t2_no_drop", 32'(bus.wr_dropped), 0);
        swap();
        chk("t2_bsel", 32'(bus.buffer_select), 1);
        chk("t2_not_ready", 32'(bus.wr_ready), 0);
        tick();
        chk("t2_wait_done", 32'(bus.swap_done), 0);
        bus.read_buffer = 1;
        tick();
        chk("t2_done", 32'(bus.swap_done), 1);
        tick();
        rd(1, 5, 16'h0123, 16'h002A, "t2_idx5");
        rd(1, 319, 16'h1319, 16'h2319, "t3_idx319");
        rd(1, 320, 16'hFFFF, 16'h0000, "t3_idx320");
        rd(1, 9'h1FF, 16'hFFFF, 16'h0000, "t3_idx511");

        swap();
        chk("t4_bsel", 32'(bus.buffer_select), 0);
        wr(0, 5, 16'hDEAD, 0);
        chk("t4_dropped", 32'(bus.wr_dropped), 1);
        swap();
        chk("t4_bsel_once", 32'(bus.buffer_select), 0);
        chk("t4_dropped_kept", 32'(bus.wr_dropped), 1);
        bus.read_buffer = 0;
        tick();
        chk("t4_done", 32'(bus.swap_done), 1);
        tick();
        rd(1, 5, 16'h0123, 16'h002A, "t4_unchanged");

        wr(1, 7, 16'h0077, 0);
        wr(0, 7, 16'hBEEF, 1);
        chk("t5_bsel", 32'(bus.buffer_select), 1);
        chk("t5_drop_cleared", 32'(bus.wr_dropped), 0);
        bus.read_buffer = 1;
        tick();
        chk("t5_done", 32'(bus.swap_done), 1);
        tick();
        rd(1, 7, 16'hBEEF, 16'h0077, "t5_idx7");
        wr(0, 320, 16'h5555, 0);
        chk("t5_oob_drop", 32'(bus.wr_dropped), 1);

        swap();
        bus.read_buffer = 0;
        tick();
        chk("t6_done0", 32'(bus.swap_done), 1);
        swap();
        chk("t6_bsel1", 32'(bus.buffer_select), 1);
        chk("t6_wait", 32'(bus.wr_ready), 0);
        bus.read_buffer = 1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_clr_bsel", 32'(bus.buffer_select), 0);
        chk("t6_clr_ready", 32'(bus.wr_ready), 0);
        chk("t6_clr_drop", 32'(bus.wr_dropped), 0);
        tick();
        chk("t6_still_wait", 32'(bus.wr_ready), 0);
        bus.read_buffer = 0;
        tick();
        chk("t6_done", 32'(bus.swap_done), 1);
        chk("t6_ready", 32'(bus.wr_ready), 1);

        tick(2);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
